lsu_mem_responder: RTL and testbench

Data-memory responder sitting on the far side of the load/store interface driven by the MEM stage. It accepts one load or store request per handshake, waits a programmable latency, performs the byte/half/word access on an internal word-organised RAM, and returns sign/zero-extended read data or an error flag. It replaces the zero-latency behavioural data memory so that stall and back-pressure paths in the pipeline can be exercised.

---
 rtl/lsu_mem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Data-memory responder: word RAM behind a valid/ready load/store handshake with programmable latency.
// Define LSU_MEM_MISALIGN_CHECK_EN to report misaligned half/word accesses as errors.
module lsu_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SIZE_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept_d;
  logic             enter_resp_d;
  logic [31:0]      acc_addr_d;
  logic [31:0]      acc_wdata_d;
  logic             acc_wen_d;
  logic [2:0]       acc_f3_d;
  logic [31:0]      off_d;
  logic [IDX_W-1:0] idx_d;
  logic [31:0]      rword_d;
  logic [7:0]       rbyte_d;
  logic [15:0]      rhalf_d;
  logic [31:0]      rdata_d;
  logic [31:0]      wdata_d;
  logic [3:0]       be_d;
  logic             f3_err_d;
  logic             err_d;
  logic             misalign_d;
  logic             we_d;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Handshake and the edge on which the access is performed (RESP entry).
  always_comb begin
    accept_d     = req_valid && req_ready_q;
    enter_resp_d = 1'b0;
    if (state_q == IDLE) begin
      enter_resp_d = accept_d && (LATENCY == 1);
    end else if (state_q == WAIT) begin
      enter_resp_d = (cnt_q == 4'd0);
    end else begin
      enter_resp_d = 1'b0;
    end
  end

  // With a single-cycle latency the access happens on the accept edge, so use live request fields.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr_d  = req_addr;
      acc_wdata_d = req_wdata;
      acc_wen_d   = req_wen;
      acc_f3_d    = req_funct3;
    end else begin
      acc_addr_d  = addr_q;
      acc_wdata_d = wdata_q;
      acc_wen_d   = wen_q;
      acc_f3_d    = funct3_q;
    end
  end

`ifdef LSU_MEM_MISALIGN_CHECK_EN
  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  always_comb begin
    misalign_d = ((acc_f3_d[1:0] == 2'b01) && acc_addr_d[0]) ||
                 ((acc_f3_d == 3'b010) && (acc_addr_d[1:0] != 2'b00));
  end
`else
  assign misalign_d = 1'b0;
`endif

  // Address range check, lane selection and load extension.
  always_comb begin
    off_d    = acc_addr_d - BASE_ADDR;
    idx_d    = off_d[IDX_W+1:2];
    rword_d  = mem_q[idx_d];
    rbyte_d  = rword_d[{acc_addr_d[1:0], 3'b000} +: 8];
    rhalf_d  = acc_addr_d[1] ? rword_d[31:16] : rword_d[15:0];
    rdata_d  = 32'd0;
    wdata_d  = 32'd0;
    be_d     = 4'd0;
    f3_err_d = 1'b0;
    if (acc_wen_d) begin
      case (acc_f3_d)
        3'b000: begin
          be_d    = 4'b0001 << acc_addr_d[1:0];
          wdata_d = {4{acc_wdata_d[7:0]}};
        end
        3'b001: begin
          be_d    = acc_addr_d[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{acc_wdata_d[15:0]}};
        end
        3'b010: begin
          be_d    = 4'b1111;
          wdata_d = acc_wdata_d;
        end
        default: f3_err_d = 1'b1;
      endcase
    end else begin
      case (acc_f3_d)
        3'b000:  rdata_d = {{24{rbyte_d[7]}}, rbyte_d};
        3'b001:  rdata_d = {{16{rhalf_d[15]}}, rhalf_d};
        3'b010:  rdata_d = rword_d;
        3'b100:  rdata_d = {24'd0, rbyte_d};
        3'b101:  rdata_d = {16'd0, rhalf_d};
        default: f3_err_d = 1'b1;
      endcase
    end
    err_d = (off_d >= SIZE_BYTES) || f3_err_d || misalign_d;
    if (err_d) begin
      rdata_d = 32'd0;
      be_d    = 4'd0;
    end else begin
      rdata_d = rdata_d;
    end
    we_d = enter_resp_d && acc_wen_d && !err_d;
  end

  // RAM contents are deliberately not reset; stores land on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (!rst && we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) begin
          mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wen_q        <= 1'b0;
      funct3_q     <= 3'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept_d) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wen_q       <= req_wen;
            funct3_q    <= req_funct3;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            if (enter_resp_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rdata_d;
              resp_err_q   <= err_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (enter_resp_d) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_lsu_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [31:0] req_addr1 = 32'd0;
  logic        req_wen1 = 1'b0;
  logic [31:0] req_wdata1 = 32'd0;
  logic [2:0]  req_funct31 = 3'd0;
  logic        resp_valid1;
  logic [31:0] resp_rdata1;
  logic        resp_err1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  lsu_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_funct3(req_funct3), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  lsu_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .req_wen(req_wen1), .req_wdata(req_wdata1), .req_funct3(req_funct31), .resp_valid(resp_valid1),
    .resp_ready(1'b1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [2:0] f, input logic [31:0] er, input logic ee);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = wd; req_funct3 = f;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.rdata = er; e.err = ee; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !req_ready) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares every presented response against the queue head.
  initial begin : mon
    bit seen = 1'b0;
    bit chk_rdy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        chk_rdy = 1'b0;
      end else begin
        if (chk_rdy) begin
          chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
          chk_rdy = 1'b0;
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            if (!seen) begin
              chk("latency", 32'(cyc - e.acc), 32'(LAT));
              seen = 1'b1;
            end
            chk("rdata", resp_rdata, e.rdata);
            chk("err", {31'd0, resp_err}, {31'd0, e.err});
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            if (resp_ready) begin
              void'(exp_q.pop_front());
              seen = 1'b0;
              chk_rdy = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);

    issue(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'd0, 1'b0);
    issue(32'h8000_0010, 1'b0, 32'd0, 3'b010, 32'hDEAD_BEEF, 1'b0);
    issue(32'h8000_0013, 1'b1, 32'h0000_005A, 3'b000, 32'd0, 1'b0);
    issue(32'h8000_0010, 1'b0, 32'd0, 3'b010, 32'h5AAD_BEEF, 1'b0);
    issue(32'h8000_0012, 1'b0, 32'd0, 3'b000, 32'hFFFF_FFAD, 1'b0);
    issue(32'h8000_0012, 1'b0, 32'd0, 3'b100, 32'h0000_00AD, 1'b0);
    issue(32'h8000_0013, 1'b0, 32'd0, 3'b000, 32'h0000_005A, 1'b0);
    issue(32'h8000_0010, 1'b0, 32'd0, 3'b001, 32'hFFFF_BEEF, 1'b0);
    issue(32'h8000_0010, 1'b0, 32'd0, 3'b101, 32'h0000_BEEF, 1'b0);
    issue(32'h8000_0012, 1'b0, 32'd0, 3'b001, 32'h0000_5AAD, 1'b0);

    issue(32'h8000_0020, 1'b1, 32'hCAFE_F00D, 3'b010, 32'd0, 1'b0);
    issue(32'h8000_0FFC, 1'b1, 32'h1111_1111, 3'b010, 32'd0, 1'b0);
    issue(32'h7FFF_FFFC, 1'b1, 32'h9999_9999, 3'b010, 32'd0, 1'b1);
    issue(32'h8000_0FFC, 1'b0, 32'd0, 3'b010, 32'h1111_1111, 1'b0);
    issue(32'h8000_1000, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
    issue(32'h8000_0010, 1'b0, 32'hFFFF_FFFF, 3'b011, 32'd0, 1'b1);
    issue(32'h8000_0010, 1'b1, 32'h7777_7777, 3'b011, 32'd0, 1'b1);
    issue(32'h8000_0010, 1'b0, 32'd0, 3'b010, 32'h5AAD_BEEF, 1'b0);

    // Back-pressure: response held for five cycles.
    drain();
    @(posedge clk); #1 resp_ready = 1'b0;
    issue(32'h8000_0010, 1'b0, 32'd0, 3'b000, 32'hFFFF_FFEF, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) chk("bp_resp_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    #1 resp_ready = 1'b1;

    // Reset while the store is in WAIT: nothing committed, no response.
    drain();
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b1;
    req_wdata = 32'h1234_5678; req_funct3 = 3'b010;
    @(posedge clk); #1 rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("wait_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("wait_rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    issue(32'h8000_0020, 1'b0, 32'd0, 3'b010, 32'hCAFE_F00D, 1'b0);

`ifdef LSU_MEM_MISALIGN_CHECK_EN
    issue(32'h8000_0011, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
    issue(32'h8000_0013, 1'b0, 32'd0, 3'b101, 32'd0, 1'b1);
`else
    issue(32'h8000_0011, 1'b0, 32'd0, 3'b010, 32'h5AAD_BEEF, 1'b0);
    issue(32'h8000_0013, 1'b0, 32'd0, 3'b101, 32'h0000_5AAD, 1'b0);
`endif
    drain();

    // LATENCY=1 instance: response one cycle after accept.
    @(negedge clk);
    chk("l1_req_ready", {31'd0, req_ready1}, 32'd1);
    req_valid1 = 1'b1; req_addr1 = 32'h8000_0004; req_wen1 = 1'b1;
    req_wdata1 = 32'h0102_0304; req_funct31 = 3'b010;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("l1_sw_valid", {31'd0, resp_valid1}, 32'd1);
    chk("l1_sw_err", {31'd0, resp_err1}, 32'd0);
    chk("l1_sw_rdata", resp_rdata1, 32'd0);
    @(negedge clk);
    chk("l1_req_ready_after", {31'd0, req_ready1}, 32'd1);
    chk("l1_valid_dropped", {31'd0, resp_valid1}, 32'd0);
    req_valid1 = 1'b1; req_wen1 = 1'b0; req_wdata1 = 32'd0;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("l1_lw_valid", {31'd0, resp_valid1}, 32'd1);
    chk("l1_lw_rdata", resp_rdata1, 32'h0102_0304);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
